mem_arbiter: RTL and testbench

- Parametrised successor to the single-master byte bus between the CPU and RAM/HCI-IO.
- Arbitrates NUM_PORTS requesters, e.g. port 0 = instruction fetch, port 1 = load/store, onto the one byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din).
- Sequences 1..4-byte little-endian transfers byte by byte and pauses cleanly on rdy=0, while HCI owns the bus.
- Sits inside cpu, between the pipeline front-ends and the top-level RAM/IO mux.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter_rr_arbiter.sv | 37 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-port byte-bus arbiter: FSM states,
// length codes, the IO region tag and small helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [1:0] IO_REGION_TAG = 2'b11;

    // Transfer length is encoded as byte count minus one.
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_3B = 2'd2;
    localparam logic [1:0] LEN_4B = 2'd3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake plus the byte-wide memory bus, bundled so the
// arbiter and its surroundings share one definition.
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
    logic [NUM_PORTS*2-1:0]          len;
    logic [NUM_PORTS*32-1:0]         wdata;
    logic [NUM_PORTS-1:0]            done;
    logic [31:0]                     rdata;
    logic                            busy;
    logic [7:0]                      mem_din;
    logic [7:0]                      mem_dout;
    logic [ADDR_WIDTH-1:0]           mem_a;
    logic                            mem_wr;

    // The arbiter's view.
    modport slave (
        input  req, we, addr, len, wdata, mem_din,
        output done, rdata, busy, mem_dout, mem_a, mem_wr
    );

    // The requesters' and RAM/IO mux's combined view.
    modport master (
        output req, we, addr, len, wdata, mem_din,
        input  done, rdata, busy, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin pick: the first requesting port strictly above last_grant,
// otherwise the lowest requesting port (wrap-around).
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && req[i] && (IDX_W'(i) > last_grant)) begin
                valid     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && req[i]) begin
                valid     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences 1..4-byte little-endian transfers from
// NUM_PORTS requesters onto the single byte-wide RAM/IO bus, freezing on rdy=0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    mem_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    state_e                 state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [NUM_PORTS-1:0]   done_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [1:0]             len_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic [2:0]             issue_cnt;
    logic [1:0]             cap_cnt;
    logic                   pend_q;

    logic [NUM_PORTS-1:0]   arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [1:0]             sel_len;
    logic [31:0]            sel_wdata;
    logic                   issuing;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    // Pull the winning port's request fields out of the flat port buses.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = bus.len[i*2 +: 2];
                sel_wdata = bus.wdata[i*32 +: 32];
            end
        end
    end

    // A byte address is on the bus only while bytes remain to issue; otherwise
    // mem_a parks at 0 so an IO address never lingers and gets re-read.
    assign issuing      = (state == ST_XFER) && (issue_cnt <= {1'b0, len_q});
    assign bus.mem_a    = issuing ? addr_q + ADDR_WIDTH'(issue_cnt) : '0;
    assign bus.mem_wr   = issuing && we_q && rdy;
    assign bus.mem_dout = (issuing && we_q) ? byte_sel(wdata_q, issue_cnt[1:0]) : 8'h00;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant_idx  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            pend_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples pre-edge values.
            done_q <= '0;
            // Capture runs even while paused: the RAM still returns a byte
            // addressed in the last rdy=1 cycle.
            pend_q <= issuing && !we_q && rdy;
            if (pend_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (cap_cnt == 2'(b)) rdata_q[8*b +: 8] <= bus.mem_din;
                end
                cap_cnt <= cap_cnt + 2'd1;
                if (cap_cnt == len_q) state <= ST_FIN;
            end
            if (rdy) begin
                case (state)
                    ST_IDLE: begin
                        if (arb_valid) begin
                            grant_idx <= arb_idx;
                            grant_q   <= arb_grant;
                            we_q      <= sel_we;
                            addr_q    <= sel_addr;
                            len_q     <= sel_len;
                            wdata_q   <= sel_wdata;
                            rdata_q   <= '0;
                            issue_cnt <= '0;
                            cap_cnt   <= '0;
                            state     <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (issuing) begin
                            issue_cnt <= issue_cnt + 3'd1;
                            if (we_q && (issue_cnt[1:0] == len_q)) state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        done_q     <= grant_q;
                        last_grant <= grant_idx;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reads, writes, contention,
// rdy pauses, reset mid-transfer, address wrap and single-touch IO reads.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;

    int n_checks;
    int n_errors;

    mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed read contents for the addresses the tests touch.
    function automatic logic [7:0] rom_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_0300: return 8'hA5;
            32'hFFFF_FFFE: return 8'hA1;
            32'hFFFF_FFFF: return 8'hB2;
            32'h0000_0000: return 8'hC3;
            32'h0000_0001: return 8'hD4;
            32'h0003_0000: return 8'h3C;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Folds the sparse test addresses into a small table index.
    function automatic int ix(input logic [31:0] a);
        return int'({a[17:16], a[9:0]});
    endfunction

    int          rd_cnt  [4096];
    int          wr_cnt  [4096];
    logic [7:0]  wr_data [4096];

    // RAM/IO model: one-cycle read latency, garbage while HCI owns the bus.
    always @(posedge clk) begin
        bus.mem_din <= rdy ? rom_rd(bus.mem_a) : 8'hEE;
        if (bus.mem_wr) begin
            wr_data[ix(bus.mem_a)] <= bus.mem_dout;
            wr_cnt[ix(bus.mem_a)]  <= wr_cnt[ix(bus.mem_a)] + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.busy && rdy && !bus.mem_wr)
            rd_cnt[ix(bus.mem_a)] <= rd_cnt[ix(bus.mem_a)] + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [31:0] a,
                            input logic [1:0] l, input logic [31:0] d);
        bus.we[p]              = w;
        bus.addr[p*32 +: 32]   = a;
        bus.len[p*2 +: 2]      = l;
        bus.wdata[p*32 +: 32]  = d;
    endtask

    // Steps until a done pulse or the budget runs out; lat counts cycles since grant.
    task automatic wait_done(input int start, input int budget, output int lat, output logic [1:0] d);
        lat = start;
        d   = 2'b00;
        while (lat < budget) begin
            next();
            lat++;
            if (bus.done !== 2'b00) begin
                d = bus.done;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [1:0]  d;
        logic [1:0]  seen;
        logic [1:0]  seq    [4];
        logic [31:0] seq_rd [4];
        int          n_done;
        int          cyc;
        int          base_a;
        int          base_b;
        int          base_rd [4];
        logic [31:0] io_addr;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        rdy       = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.len   = '0;
        bus.wdata = '0;
        #3;
        check("reset_done",     bus.done,     2'b00);
        check("reset_rdata",    bus.rdata,    32'h0);
        check("reset_busy",     bus.busy,     1'b0);
        check("reset_mem_a",    bus.mem_a,    32'h0);
        check("reset_mem_wr",   bus.mem_wr,   1'b0);
        check("reset_mem_dout", bus.mem_dout, 8'h00);
        next();
        next();
        rst_n = 1'b1;
        next();

        // Single 4-byte read on port 0.
        set_port(0, 1'b0, 32'h100, LEN_4B, 32'h0);
        bus.req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            next();
            check("read_mem_a", bus.mem_a, 32'h100 + c - 1);
            check("read_mem_wr", bus.mem_wr, 1'b0);
        end
        check("read_busy", bus.busy, 1'b1);
        wait_done(4, 20, lat, d);
        bus.req = 2'b00;
        check("read_latency", lat, 7);
        check("read_done", d, 2'b01);
        check("read_rdata", bus.rdata, 32'h4433_2211);

        // Single 2-byte write on port 1; rdata must be cleared by the grant.
        base_a = wr_cnt[ix(32'h202)];
        set_port(1, 1'b1, 32'h200, LEN_2B, 32'hDEAD_BEEF);
        bus.req = 2'b10;
        next();
        check("write_b0_wr",   bus.mem_wr,   1'b1);
        check("write_b0_a",    bus.mem_a,    32'h200);
        check("write_b0_dout", bus.mem_dout, 8'hEF);
        next();
        check("write_b1_wr",   bus.mem_wr,   1'b1);
        check("write_b1_a",    bus.mem_a,    32'h201);
        check("write_b1_dout", bus.mem_dout, 8'hBE);
        next();
        check("write_fin_wr", bus.mem_wr, 1'b0);
        wait_done(3, 20, lat, d);
        bus.req = 2'b00;
        check("write_latency", lat, 4);
        check("write_done", d, 2'b10);
        check("write_rdata_clr", bus.rdata, 32'h0);
        check("write_ram_200", wr_data[ix(32'h200)], 8'hEF);
        check("write_ram_201", wr_data[ix(32'h201)], 8'hBE);
        check("write_none_202", wr_cnt[ix(32'h202)] - base_a, 0);

        // Both ports requesting continuously: grants alternate 0,1,0,1.
        set_port(0, 1'b0, 32'h300, LEN_1B, 32'h0);
        set_port(1, 1'b1, 32'h400, LEN_1B, 32'h0000_0077);
        for (int k = 0; k < 4; k++) begin
            seq[k]    = 2'b00;
            seq_rd[k] = 32'hFFFF_FFFF;
        end
        bus.req = 2'b11;
        n_done  = 0;
        cyc     = 0;
        while (n_done < 4 && cyc < 80) begin
            next();
            cyc++;
            if (bus.done !== 2'b00) begin
                seq[n_done]    = bus.done;
                seq_rd[n_done] = bus.rdata;
                n_done++;
                if (n_done == 4) bus.req = 2'b00;
            end
        end
        check("arb_count", n_done, 4);
        for (int k = 0; k < 4; k++) begin
            check("arb_order", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            check("arb_rdata", seq_rd[k], (k % 2 == 0) ? 32'h0000_00A5 : 32'h0);
        end
        check("arb_write_data", wr_data[ix(32'h400)], 8'h77);

        // 4-byte read paused for 3 cycles right after byte 1 is issued.
        for (int k = 0; k < 4; k++) base_rd[k] = rd_cnt[ix(32'h100 + k)];
        base_a = wr_cnt[ix(32'h100)];
        set_port(0, 1'b0, 32'h100, LEN_4B, 32'h0);
        bus.req = 2'b01;
        next();
        check("pause_a0", bus.mem_a, 32'h100);
        next();
        check("pause_a1", bus.mem_a, 32'h101);
        next();
        rdy = 1'b0;
        #1;
        check("pause_mem_wr", bus.mem_wr, 1'b0);
        next();
        next();
        next();
        rdy = 1'b1;
        #1;
        check("pause_reissue_a2", bus.mem_a, 32'h102);
        wait_done(6, 30, lat, d);
        bus.req = 2'b00;
        check("pause_latency", lat, 10);
        check("pause_done", d, 2'b01);
        check("pause_rdata", bus.rdata, 32'h4433_2211);
        for (int k = 0; k < 4; k++)
            check("pause_read_once", rd_cnt[ix(32'h100 + k)] - base_rd[k], 1);
        check("pause_no_write", wr_cnt[ix(32'h100)] - base_a, 0);

        // Reset asserted while byte 2 of a write is on the bus.
        base_a = wr_cnt[ix(32'h502)];
        base_b = wr_cnt[ix(32'h501)];
        set_port(1, 1'b1, 32'h500, LEN_4B, 32'h0403_0201);
        bus.req = 2'b10;
        next();
        next();
        next();
        check("rstmid_pre_wr", bus.mem_wr, 1'b1);
        check("rstmid_pre_a", bus.mem_a, 32'h502);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        #1;
        check("rstmid_done",   bus.done,     2'b00);
        check("rstmid_mem_wr", bus.mem_wr,   1'b0);
        check("rstmid_mem_a",  bus.mem_a,    32'h0);
        check("rstmid_busy",   bus.busy,     1'b0);
        check("rstmid_dout",   bus.mem_dout, 8'h00);
        check("rstmid_rdata",  bus.rdata,    32'h0);
        next();
        next();
        rst_n = 1'b1;
        seen  = 2'b00;
        for (int k = 0; k < 6; k++) begin
            next();
            seen = seen | bus.done;
        end
        check("rstmid_no_done", seen, 2'b00);
        check("rstmid_no_b2", wr_cnt[ix(32'h502)] - base_a, 0);
        check("rstmid_b1_once", wr_cnt[ix(32'h501)] - base_b, 1);
        set_port(0, 1'b0, 32'h300, LEN_1B, 32'h0);
        set_port(1, 1'b0, 32'h100, LEN_1B, 32'h0);
        bus.req = 2'b11;
        wait_done(0, 20, lat, d);
        bus.req = 2'b00;
        check("rstmid_first_port", d, 2'b01);
        check("rstmid_latency", lat, 4);
        check("rstmid_rdata", bus.rdata, 32'h0000_00A5);

        // Address wrap across the top of the address space.
        set_port(0, 1'b0, 32'hFFFF_FFFE, LEN_4B, 32'h0);
        bus.req = 2'b01;
        next();
        check("wrap_a0", bus.mem_a, 32'hFFFF_FFFE);
        next();
        check("wrap_a1", bus.mem_a, 32'hFFFF_FFFF);
        next();
        check("wrap_a2", bus.mem_a, 32'h0000_0000);
        next();
        check("wrap_a3", bus.mem_a, 32'h0000_0001);
        wait_done(4, 20, lat, d);
        bus.req = 2'b00;
        check("wrap_latency", lat, 7);
        check("wrap_done", d, 2'b01);
        check("wrap_rdata", bus.rdata, 32'hD4C3_B2A1);

        // 1-byte IO read: the address must appear for exactly one cycle.
        io_addr    = {14'd0, IO_REGION_TAG, 16'd0};
        base_a     = rd_cnt[ix(io_addr)];
        set_port(0, 1'b0, io_addr, LEN_1B, 32'h0);
        bus.req = 2'b01;
        wait_done(0, 20, lat, d);
        bus.req = 2'b00;
        check("io_latency", lat, 4);
        check("io_done", d, 2'b01);
        check("io_rdata", bus.rdata, 32'h0000_003C);
        check("io_read_once", rd_cnt[ix(io_addr)] - base_a, 1);
        next();
        check("io_idle_mem_a", bus.mem_a, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
